// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared types and constants for the FIR stream controller (FIR_FLUSH_EN adds ST_FLUSH)
package fir_ctrl_pkg;

    localparam int FIR_DATA_W = 32;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
`ifdef FIR_FLUSH_EN
        , ST_FLUSH
`endif
    } state_e;

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// rtl/fir_stream_ctrl_if.sv - sample, result and FIR-side signals of the controller (FIR_FLUSH_EN adds flush)
interface fir_stream_ctrl_if
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W     = FIR_DATA_W,
    parameter int FIFO_DEPTH = 8
) ();

    logic [DATA_W-1:0]           in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           fir_data_in;
    logic                        fir_load;
    logic [DATA_W-1:0]           fir_data_out;
    logic                        fir_busy;
`ifdef FIR_FLUSH_EN
    logic                        flush;
`endif
    logic                        wdog_err;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    // Controller side
    modport slave (
        input  in_data, in_valid, out_ready, fir_data_out, fir_busy,
`ifdef FIR_FLUSH_EN
        input  flush,
`endif
        output in_ready, out_data, out_valid, fir_data_in, fir_load, wdog_err, fifo_level
    );

    // Source / consumer / FIR side
    modport master (
        output in_data, in_valid, out_ready, fir_data_out, fir_busy,
`ifdef FIR_FLUSH_EN
        output flush,
`endif
        input  in_ready, out_data, out_valid, fir_data_in, fir_load, wdog_err, fifo_level
    );

endinterface

// File: rtl/fir_sample_fifo.sv
// rtl/fir_sample_fifo.sv - synchronous sample FIFO with full/empty/level, async active-low reset
module fir_sample_fifo
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              push_ok, pop_ok;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // a push into a full FIFO is only legal when the head leaves in the same cycle
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // pointer/level registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // sample storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - FIR streaming front-end: input FIFO, issue FSM, watchdog, held result (FIR_FLUSH_EN enables flush)
module fir_stream_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W     = FIR_DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_TAPS   = 8,
    parameter int WDOG_MAX   = 64
) (
    input  logic             clk,
    input  logic             rst,
    fir_stream_ctrl_if.slave bus
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(WDOG_MAX + 1);

    state_e            state_q, state_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              wdog_err_q, wdog_err_d;
    logic              rdy_en_q;
    logic              fir_load;
    logic [DATA_W-1:0] fir_data;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [LW-1:0]     fifo_level;
`ifdef FIR_FLUSH_EN
    localparam int TW = $clog2(NUM_TAPS + 1);
    logic              flush_pend_q, flush_pend_d;
    logic [TW-1:0]     tap_cnt_q, tap_cnt_d;
    logic              tap_wait_q, tap_wait_d;
`endif

    // head is consumed exactly in the ISSUE cycle, which also frees a slot for a same-cycle push
    assign fifo_pop     = (state_q == ST_ISSUE);
    assign bus.in_ready = rdy_en_q && (!fifo_full || fifo_pop);
    assign fifo_push    = bus.in_valid && bus.in_ready;

    fir_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.in_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.fifo_level  = fifo_level;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.wdog_err    = wdog_err_q;
    assign bus.fir_load    = fir_load;
    assign bus.fir_data_in = fir_data;

    // next state, FIR strobe, watchdog and result capture
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        wdog_err_d  = wdog_err_q;
        fir_load    = 1'b0;
        fir_data    = DATA_W'(FP_ZERO);
`ifdef FIR_FLUSH_EN
        flush_pend_d = (state_q != ST_IDLE) && (flush_pend_q || bus.flush);
        tap_cnt_d    = tap_cnt_q;
        tap_wait_d   = tap_wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FIR_FLUSH_EN
                if (flush_pend_q || bus.flush) begin
                    state_d    = ST_FLUSH;
                    tap_cnt_d  = '0;
                    tap_wait_d = 1'b0;
                end else
`endif
                // a result leaving this cycle frees the register for the next issue
                if (!fifo_empty && (!out_valid_q || bus.out_ready)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fir_load = 1'b1;
                fir_data = fifo_head;
                wcnt_d   = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.fir_busy) begin
                    out_data_d  = bus.fir_data_out;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (wcnt_q == WW'(WDOG_MAX - 1)) begin
                    wdog_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
`ifdef FIR_FLUSH_EN
            ST_FLUSH: begin
                if (!tap_wait_q) begin
                    fir_load   = 1'b1;
                    tap_wait_d = 1'b1;
                    wcnt_d     = '0;
                end else if (!bus.fir_busy) begin
                    if (tap_cnt_q == TW'(NUM_TAPS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        tap_cnt_d  = tap_cnt_q + TW'(1);
                        tap_wait_d = 1'b0;
                    end
                end else if (wcnt_q == WW'(WDOG_MAX - 1)) begin
                    wdog_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // controller registers; any in-flight FIR result is dropped on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            wdog_err_q  <= 1'b0;
            rdy_en_q    <= 1'b0;
`ifdef FIR_FLUSH_EN
            flush_pend_q <= 1'b0;
            tap_cnt_q    <= '0;
            tap_wait_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            wdog_err_q  <= wdog_err_d;
            rdy_en_q    <= 1'b1;
`ifdef FIR_FLUSH_EN
            flush_pend_q <= flush_pend_d;
            tap_cnt_q    <= tap_cnt_d;
            tap_wait_q   <= tap_wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - directed bench for fir_stream_ctrl with a negating FIR model (FIR_FLUSH_EN adds the flush case)
module tb_fir_stream_ctrl;
    import fir_ctrl_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TAPS  = 8;
    localparam int WDOG  = 64;
    localparam int HALF  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #HALF clk = ~clk;

    fir_stream_ctrl_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    fir_stream_ctrl #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .NUM_TAPS   (TAPS),
        .WDOG_MAX   (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIR model: busy for busy_cyc cycles after a load, result is the sign-flipped sample
    int          busy_cyc = 4;
    bit          hang     = 1'b0;
    logic [31:0] fir_lat;
    int          fcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.fir_busy     <= 1'b0;
            bus.fir_data_out <= '0;
            fir_lat          <= '0;
            fcnt             <= 0;
        end else if (bus.fir_load) begin
            fir_lat      <= bus.fir_data_in;
            fcnt         <= busy_cyc;
            bus.fir_busy <= 1'b1;
        end else if (bus.fir_busy && !hang) begin
            if (fcnt <= 1) begin
                bus.fir_busy     <= 1'b0;
                bus.fir_data_out <= fir_lat ^ 32'h8000_0000;
            end else begin
                fcnt <= fcnt - 1;
            end
        end
    end

    // monitor just before each rising edge
    logic [31:0] load_q[$];
    int          load_cyc_q[$];
    logic [31:0] res_q[$];
    int          rise_q[$];
    int          wdog_cyc = -1;
    bit          ov_prev  = 1'b0;
    always @(negedge clk) begin
        #(HALF - 1);
        if (rst) begin
            if (bus.fir_load) begin
                load_q.push_back(bus.fir_data_in);
                load_cyc_q.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) res_q.push_back(bus.out_data);
            if (bus.out_valid && !ov_prev) rise_q.push_back(cyc);
            if (bus.wdog_err && wdog_cyc < 0) wdog_cyc = cyc;
        end
        ov_prev = bus.out_valid;
    end

    int push_cyc;

    task automatic push(input logic [31:0] d);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        push_cyc     = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int k = 0;
        while (res_q.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("res_count", res_q.size(), n);
    endtask

    task automatic wait_loads(input int n);
        int k = 0;
        while (load_q.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("load_count", load_q.size(), n);
    endtask

    int p1, c0, p9, lb, rb;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef FIR_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready",   {31'd0, bus.in_ready},  32'd0);
        chk("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",   bus.out_data,           32'd0);
        chk("rst_fir_load",   {31'd0, bus.fir_load},  32'd0);
        chk("rst_fir_data",   bus.fir_data_in,        32'd0);
        chk("rst_wdog",       {31'd0, bus.wdog_err},  32'd0);
        chk("rst_level",      32'(bus.fifo_level),    32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.in_ready},  32'd1);

        // three back-to-back samples, FIR busy 4 cycles
        push(32'h3F80_0000);
        p1 = push_cyc;
        push(32'h3F00_0000);
        push(32'hBF00_0000);
        wait_res(3);
        chk("t1_load0", load_q[0], 32'h3F80_0000);
        chk("t1_load1", load_q[1], 32'h3F00_0000);
        chk("t1_load2", load_q[2], 32'hBF00_0000);
        chk("t1_res0",  res_q[0],  32'hBF80_0000);
        chk("t1_res1",  res_q[1],  32'hBF00_0000);
        chk("t1_res2",  res_q[2],  32'h3F00_0000);
        chk("t1_latency", rise_q[0] - p1, 32'd7);

        // held result under backpressure
        bus.out_ready = 1'b0;
        lb = load_q.size();
        rb = res_q.size();
        push(32'hBE99_999A);
        push(32'h3DCC_CCCD);
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        chk("t3_held",  bus.out_data, 32'h3E99_999A);
        repeat (20) @(negedge clk);
        chk("t3_noload", load_q.size(), lb + 1);
        chk("t3_stable", bus.out_data, 32'h3E99_999A);
        chk("t3_valid",  {31'd0, bus.out_valid}, 32'd1);
        chk("t3_level",  32'(bus.fifo_level),    32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_cleared",  {31'd0, bus.out_valid}, 32'd0);
        chk("t3_issue",    {31'd0, bus.fir_load},  32'd1);
        chk("t3_issue_dt", bus.fir_data_in,        32'h3DCC_CCCD);
        wait_res(rb + 2);
        chk("t3_res0", res_q[rb],     32'h3E99_999A);
        chk("t3_res1", res_q[rb + 1], 32'hBDCC_CCCD);

        // FIR hangs: fill FIFO, watchdog fires, ninth sample enters on the pop
        hang = 1'b1;
        lb = load_q.size();
        push(32'h4120_0000);
        wait_loads(lb + 1);
        c0 = load_cyc_q[lb];
        for (int i = 0; i < DEPTH; i++) push(32'h4100_0000 + 32'(i));
        chk("t2_level_full", 32'(bus.fifo_level),   32'd8);
        chk("t2_not_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("t2_no_wdog",    {31'd0, bus.wdog_err}, 32'd0);
        push(32'h4200_0000);
        p9 = push_cyc;
        chk("t4_wdog",       {31'd0, bus.wdog_err}, 32'd1);
        chk("t4_wdog_time",  wdog_cyc - c0,         32'(WDOG + 1));
        chk("t2_level_kept", 32'(bus.fifo_level),   32'd8);
        chk("t4_next_issue", load_q[lb + 1],        32'h4100_0000);
        chk("t2_same_cycle", load_cyc_q[lb + 1],    p9 - 1);

        // asynchronous reset while waiting on the FIR with a full queue
        rst = 1'b0;
        #1;
        chk("t5_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t5_level", 32'(bus.fifo_level),    32'd0);
        chk("t5_load",  {31'd0, bus.fir_load},  32'd0);
        chk("t5_ready", {31'd0, bus.in_ready},  32'd0);
        chk("t5_wdog",  {31'd0, bus.wdog_err},  32'd0);
        repeat (2) @(negedge clk);
        hang = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        lb = load_q.size();
        rb = res_q.size();
        push(32'h4049_0FDB);
        wait_res(rb + 1);
        repeat (10) @(negedge clk);
        chk("t5_one_load", load_q.size(), lb + 1);
        chk("t5_load_dt",  load_q[lb],    32'h4049_0FDB);
        chk("t5_res",      res_q[rb],     32'hC049_0FDB);

`ifdef FIR_FLUSH_EN
        // flush: eight zero loads, then the sample pushed during the flush
        busy_cyc = 2;
        lb = load_q.size();
        rb = res_q.size();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        push(32'hBE4C_CCCD);
        wait_loads(lb + TAPS + 1);
        for (int i = 0; i < TAPS; i++) chk("t6_zero_load", load_q[lb + i], 32'd0);
        chk("t6_no_result", res_q.size(), rb);
        chk("t6_issue", load_q[lb + TAPS], 32'hBE4C_CCCD);
        wait_res(rb + 1);
        chk("t6_res", res_q[rb], 32'h3E4C_CCCD);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
